// File: rtl/fsm_seq_pkg.sv
// Shared types and default widths for the programmable step sequencer.
package fsm_seq_pkg;

  localparam int DFLT_NUM_STEPS = 13;
  localparam int DFLT_IDX_W     = 4;
  localparam int DFLT_IN_W      = 4;
  localparam int DFLT_CODE_W    = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DFLT_IN_W-1:0]   mask;
    logic [DFLT_IN_W-1:0]   val;
    logic                   hold;
    logic                   last;
    logic [DFLT_CODE_W-1:0] code;
  } step_entry_t;

endpackage

// File: rtl/fsm_step_table.sv
// Step table register file: one synchronous write port, combinational reads of the
// current step's control fields and of any step's code; everything clears on reset.
module fsm_step_table
  import fsm_seq_pkg::*;
#(
  parameter int NUM_STEPS = DFLT_NUM_STEPS,
  parameter int IDX_W     = DFLT_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DFLT_IN_W-1:0]   wr_mask,
  input  logic [DFLT_IN_W-1:0]   wr_val,
  input  logic                   wr_hold,
  input  logic                   wr_last,
  input  logic [DFLT_CODE_W-1:0] wr_code,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [DFLT_IN_W-1:0]   rd_mask,
  output logic [DFLT_IN_W-1:0]   rd_val,
  output logic                   rd_hold,
  output logic                   rd_last,
  input  logic [IDX_W-1:0]       code_idx,
  output logic [DFLT_CODE_W-1:0] code_dat
);

  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_STEPS);

  step_entry_t entries_q [NUM_STEPS];
  step_entry_t entries_d [NUM_STEPS];
  step_entry_t rd_ent;

  always_comb begin
    entries_d = entries_q;
    if (wr_en && ({1'b0, wr_idx} < DEPTH)) begin
      entries_d[wr_idx] = '{mask: wr_mask, val: wr_val, hold: wr_hold,
                            last: wr_last, code: wr_code};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '{default: '0};
    end else begin
      entries_q <= entries_d;
    end
  end

  always_comb begin
    rd_ent   = '0;
    code_dat = '0;
    if ({1'b0, rd_idx} < DEPTH) begin
      rd_ent = entries_q[rd_idx];
    end
    if ({1'b0, code_idx} < DEPTH) begin
      code_dat = entries_q[code_idx].code;
    end
  end

  assign rd_mask = rd_ent.mask;
  assign rd_val  = rd_ent.val;
  assign rd_hold = rd_ent.hold;
  assign rd_last = rd_ent.last;

endmodule

// File: rtl/fsm_step_sequencer.sv
// Programmable step sequencer: walks the loaded table one step per clock while the
// masked condition matches; step/out/state update on the edge after evaluation.
module fsm_step_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int NUM_STEPS = DFLT_NUM_STEPS,
  parameter int IDX_W     = DFLT_IDX_W,
  parameter int IN_W      = DFLT_IN_W,
  parameter int CODE_W    = DFLT_CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [IN_W-1:0]   cfg_mask,
  input  logic [IN_W-1:0]   cfg_val,
  input  logic              cfg_hold,
  input  logic              cfg_last,
  input  logic [CODE_W-1:0] cfg_code,
  input  logic              run,
  input  logic [IN_W-1:0]   in,
  output logic [CODE_W-1:0] out,
  output logic [IDX_W-1:0]  step,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [IDX_W:0]   DEPTH    = (IDX_W+1)'(NUM_STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {OUT_HOLD, OUT_CLR, OUT_LOAD} out_sel_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic [CODE_W-1:0] out_q, out_d;
  logic              cfg_err_q, cfg_err_d;
  out_sel_e          out_sel;

  logic [IN_W-1:0]   cur_mask, cur_val;
  logic              cur_hold, cur_last;
  logic [CODE_W-1:0] tbl_code, nxt_code;
  logic              wr_ok, match;

  assign wr_ok = cfg_we && (state_q != ARMED) && ({1'b0, cfg_idx} < DEPTH);
  assign match = (((in ^ cur_val) & cur_mask) == '0);

  fsm_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_ok),
    .wr_idx   (cfg_idx),
    .wr_mask  (cfg_mask),
    .wr_val   (cfg_val),
    .wr_hold  (cfg_hold),
    .wr_last  (cfg_last),
    .wr_code  (cfg_code),
    .rd_idx   (step_q),
    .rd_mask  (cur_mask),
    .rd_val   (cur_val),
    .rd_hold  (cur_hold),
    .rd_last  (cur_last),
    .code_idx (step_d),
    .code_dat (tbl_code)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    out_sel   = OUT_HOLD;
    cfg_err_d = cfg_we && !wr_ok;
    case (state_q)
      IDLE: begin
        step_d  = '0;
        out_sel = OUT_CLR;
        if (run) begin
          state_d = ARMED;
          out_sel = OUT_LOAD;
        end
      end
      ARMED: begin
        if (!run) begin
          state_d = IDLE;
          step_d  = '0;
          out_sel = OUT_CLR;
        end else if (match) begin
          if (cur_last || (step_q == LAST_IDX)) begin
            state_d = DONE;
          end else begin
            step_d  = step_q + IDX_W'(1);
            out_sel = OUT_LOAD;
          end
        end else if (!cur_hold) begin
          step_d  = '0;
          out_sel = OUT_LOAD;
        end
      end
      DONE: begin
        if (!run) begin
          state_d = IDLE;
          step_d  = '0;
          out_sel = OUT_CLR;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        out_sel = OUT_CLR;
      end
    endcase
  end

  // A same-cycle write to the entry being entered must show on out immediately.
  always_comb begin
    nxt_code = (wr_ok && (cfg_idx == step_d)) ? cfg_code : tbl_code;
    case (out_sel)
      OUT_CLR:  out_d = '0;
      OUT_LOAD: out_d = nxt_code;
      default:  out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out     = out_q;
  assign step    = step_q;
  assign busy    = (state_q == ARMED);
  assign done    = (state_q == DONE);
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Self-checking bench for fsm_step_sequencer: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the step table.
module tb_fsm_step_sequencer;

  localparam int NS = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [3:0]  cfg_mask;
  logic [3:0]  cfg_val;
  logic        cfg_hold;
  logic        cfg_last;
  logic [16:0] cfg_code;
  logic        run;
  logic [3:0]  in_v;
  logic [16:0] out;
  logic [3:0]  step;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain arrays and an integer mode (0 idle, 1 armed, 2 done).
  logic [3:0]  m_mask [NS];
  logic [3:0]  m_val  [NS];
  logic        m_hold [NS];
  logic        m_last [NS];
  logic [16:0] m_code [NS];
  int          m_mode;
  int          m_step;
  logic [16:0] m_out;
  logic        m_err;

  always #5 clk = ~clk;

  fsm_step_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_mask (cfg_mask),
    .cfg_val  (cfg_val),
    .cfg_hold (cfg_hold),
    .cfg_last (cfg_last),
    .cfg_code (cfg_code),
    .run      (run),
    .in       (in_v),
    .out      (out),
    .step     (step),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  s;
    bit  hit;
    bit  accept;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_mask[i] = '0; m_val[i] = '0; m_hold[i] = 1'b0; m_last[i] = 1'b0; m_code[i] = '0;
      end
      m_mode = 0; m_step = 0; m_out = '0; m_err = 1'b0;
      return;
    end
    s      = m_step;
    hit    = (((in_v ^ m_val[s]) & m_mask[s]) == 4'd0);
    accept = cfg_we && (m_mode != 1) && (int'(cfg_idx) < NS);
    m_err  = cfg_we && !accept;
    if (accept) begin
      m_mask[cfg_idx] = cfg_mask; m_val[cfg_idx] = cfg_val; m_hold[cfg_idx] = cfg_hold;
      m_last[cfg_idx] = cfg_last; m_code[cfg_idx] = cfg_code;
    end
    if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_step = 0; m_out = m_code[0]; end
    end else if (!run) begin
      m_mode = 0; m_step = 0; m_out = '0;
    end else if (m_mode == 1) begin
      if (hit) begin
        if (m_last[s] || s == NS - 1) m_mode = 2;
        else begin m_step = s + 1; m_out = m_code[s + 1]; end
      end else if (!m_hold[s]) begin
        m_step = 0; m_out = m_code[0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out",     32'(out),     32'(m_out));
    check_eq("step",    32'(step),    32'(m_step));
    check_eq("busy",    32'(busy),    32'(m_mode == 1));
    check_eq("done",    32'(done),    32'(m_mode == 2));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [3:0] mask, input logic [3:0] val,
                             input logic hold, input logic last, input logic [16:0] code);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mask = mask; cfg_val = val;
    cfg_hold = hold; cfg_last = last; cfg_code = code;
    tick();
    cfg_we = 1'b0;
  endtask

  logic [16:0] full_code [NS];

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_val = '0;
    cfg_hold = 1'b0; cfg_last = 1'b0; cfg_code = '0; run = 1'b0; in_v = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_step", 32'(step), 32'd0);

    // Basic advance through three steps.
    write_entry(4'd0, 4'b0100, 4'b0100, 1'b0, 1'b0, 17'd0);
    write_entry(4'd1, 4'b1001, 4'b1001, 1'b0, 1'b0, 17'd200);
    write_entry(4'd2, 4'b0100, 4'b0000, 1'b0, 1'b1, 17'd700);
    run = 1'b1; tick();
    check_eq("basic_arm_busy", 32'(busy), 32'd1);
    in_v = 4'b0100; tick();
    check_eq("basic_out1", 32'(out), 32'd200);
    in_v = 4'b1001; tick();
    check_eq("basic_out2", 32'(out), 32'd700);
    in_v = 4'b0000; tick();
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_done_out", 32'(out), 32'd700);
    check_eq("basic_done_step", 32'(step), 32'd2);
    in_v = 4'b1111; tick();

    // Mismatch without hold returns to step 0.
    run = 1'b0; tick();
    run = 1'b1; tick();
    in_v = 4'b0100; tick();
    in_v = 4'b0000; tick();
    check_eq("nohold_step", 32'(step), 32'd0);
    check_eq("nohold_busy", 32'(busy), 32'd1);

    // Mismatch with hold stays put.
    run = 1'b0; tick();
    write_entry(4'd1, 4'b0001, 4'b0001, 1'b1, 1'b0, 17'd200);
    run = 1'b1; tick();
    in_v = 4'b0100; tick();
    in_v = 4'b0000;
    repeat (5) begin
      tick();
      check_eq("hold_step", 32'(step), 32'd1);
    end
    in_v = 4'b0001; tick();
    check_eq("hold_adv", 32'(step), 32'd2);

    // Abort by dropping run.
    run = 1'b0; tick();
    check_eq("abort_out", 32'(out), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);

    // Reset mid-sequence clears the table; rerun walks all steps unconditionally.
    run = 1'b1; tick();
    in_v = 4'b0100; tick();
    reset = 1'b1; run = 1'b0; tick();
    reset = 1'b0;
    check_eq("midrst_out", 32'(out), 32'd0);
    run = 1'b1; in_v = 4'($urandom); tick();
    for (int i = 0; i < NS; i++) begin
      in_v = 4'($urandom);
      tick();
    end
    check_eq("rerun_done", 32'(done), 32'd1);
    check_eq("rerun_step", 32'(step), 32'd12);

    // Config guards.
    run = 1'b0; tick();
    run = 1'b1; tick();
    write_entry(4'd0, 4'b1111, 4'b1010, 1'b0, 1'b0, 17'd5);
    check_eq("guard_armed_err", 32'(cfg_err), 32'd1);
    tick();
    check_eq("guard_armed_clr", 32'(cfg_err), 32'd0);
    run = 1'b0; tick();
    write_entry(4'd13, 4'b1111, 4'b1111, 1'b1, 1'b1, 17'd9);
    check_eq("guard_idx_err", 32'(cfg_err), 32'd1);
    tick();
    check_eq("guard_idx_clr", 32'(cfg_err), 32'd0);
    run = 1'b1;
    write_entry(4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 17'h1abcd);
    check_eq("wr_run_out", 32'(out), 32'h1abcd);

    // Full depth, nothing marked last, everything matching.
    run = 1'b0; tick();
    for (int i = 0; i < NS; i++) begin
      full_code[i] = 17'($urandom);
      write_entry(4'(i), 4'b0000, 4'($urandom), 1'($urandom), 1'b0, full_code[i]);
    end
    run = 1'b1;
    repeat (NS + 2) begin
      in_v = 4'($urandom);
      tick();
    end
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_step", 32'(step), 32'd12);
    check_eq("full_out", 32'(out), 32'(full_code[12]));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      run      = ($urandom_range(0, 15) != 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_idx  = 4'($urandom);
      cfg_mask = 4'($urandom & $urandom);
      cfg_val  = 4'($urandom);
      cfg_hold = 1'($urandom);
      cfg_last = ($urandom_range(0, 7) == 0);
      cfg_code = 17'($urandom);
      in_v     = 4'($urandom);
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
